adder_seq: RTL

ADDER_SEQ -- requirements
Module: adder_seq

---
 rtl/adder_seq_pkg.sv | 20 ++
 rtl/adder_seq_adder.sv | 45 ++++
 rtl/adder_seq.sv | 83 ++++++++
 3 files changed

// File: rtl/adder_seq_pkg.sv
// rtl/adder_seq_pkg.sv - shared width, state encodings and adder write-select codes
package adder_seq_pkg;

    localparam int DATA_WIDTH = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LD_A  = 3'd1,
        LD_B  = 3'd2,
        LD_OP = 3'd3,
        CAPT  = 3'd4,
        RSP   = 3'd5
    } state_t;

    localparam logic [1:0] WEN_IDLE = 2'b00;
    localparam logic [1:0] WEN_IN1  = 2'b01;
    localparam logic [1:0] WEN_IN2  = 2'b10;
    localparam logic [1:0] WEN_OP   = 2'b11;

endpackage

// File: rtl/adder_seq_adder.sv
// rtl/adder_seq_adder.sv - register-loaded adder/subtractor driven by adder_seq
module adder_seq_adder #(
    parameter int DATA_WIDTH = adder_seq_pkg::DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            wen,
    input  logic [DATA_WIDTH-1:0] data_in1,
    input  logic [DATA_WIDTH-1:0] data_in2,
    input  logic                  op,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  carry
);
    import adder_seq_pkg::*;

    logic [DATA_WIDTH-1:0] in1_q;
    logic [DATA_WIDTH-1:0] in2_q;
    logic [DATA_WIDTH:0]   sum;

    // Operand registers loaded by write select; the op strobe has no storage
    // because the result follows the live op input.
    always_ff @(posedge clk) begin
        if (rst) begin
            in1_q <= '0;
            in2_q <= '0;
        end else begin
            if (wen == WEN_IN1) in1_q <= data_in1;
            if (wen == WEN_IN2) in2_q <= data_in2;
        end
    end

    // Subtract is a + ~b + 1, so carry out means "no borrow".
    always_comb begin
        sum = '0;
        if (op) begin
            sum = {1'b0, in1_q} + {1'b0, ~in2_q} + {{DATA_WIDTH{1'b0}}, 1'b1};
        end else begin
            sum = {1'b0, in1_q} + {1'b0, in2_q};
        end
    end

    assign data_o = sum[DATA_WIDTH-1:0];
    assign carry  = sum[DATA_WIDTH];

endmodule

// File: rtl/adder_seq.sv
// rtl/adder_seq.sv - sequences one add/subtract request through an external register-loaded adder
module adder_seq #(
    parameter int DATA_WIDTH = adder_seq_pkg::DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [DATA_WIDTH-1:0] req_a,
    input  logic [DATA_WIDTH-1:0] req_b,
    input  logic                  req_op,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_carry,
    output logic [DATA_WIDTH-1:0] add_data_in1,
    output logic [DATA_WIDTH-1:0] add_data_in2,
    output logic                  add_op,
    output logic [1:0]            add_wen,
    input  logic [DATA_WIDTH-1:0] add_data_o,
    input  logic                  add_carry
);
    import adder_seq_pkg::*;

    state_t state;

    // The operand output registers double as the request latch: they are
    // loaded on accept and held until the result is captured.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            add_wen      <= WEN_IDLE;
            add_data_in1 <= '0;
            add_data_in2 <= '0;
            add_op       <= 1'b0;
            rsp_data     <= '0;
            rsp_carry    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        state        <= LD_A;
                        add_wen      <= WEN_IN1;
                        add_data_in1 <= req_a;
                        add_data_in2 <= req_b;
                        add_op       <= req_op;
                    end
                end
                LD_A: begin
                    state   <= LD_B;
                    add_wen <= WEN_IN2;
                end
                LD_B: begin
                    state   <= LD_OP;
                    add_wen <= WEN_OP;
                end
                LD_OP: begin
                    state   <= CAPT;
                    add_wen <= WEN_IDLE;
                end
                CAPT: begin
                    state        <= RSP;
                    rsp_data     <= add_data_o;
                    rsp_carry    <= add_carry;
                    add_data_in1 <= '0;
                    add_data_in2 <= '0;
                    add_op       <= 1'b0;
                end
                RSP: begin
                    if (rsp_ready) state <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    add_wen <= WEN_IDLE;
                end
            endcase
        end
    end

    assign req_ready = (state == IDLE) && !rst;
    assign rsp_valid = (state == RSP);

endmodule
